// File: rtl/main_mem_pkg.sv
// rtl/main_mem_pkg.sv - shared widths, pipeline stage type and address helpers for main_mem_responder
package main_mem_pkg;
    localparam int WORD_W          = 16;
    localparam int ADDR_W          = 16;
    localparam int DEFAULT_LATENCY = 4;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [WORD_W-1:0] data;
    } pipe_stage_t;

    // Byte address to word index; bit 0 selects a byte lane and never addresses storage.
    function automatic logic [ADDR_W-2:0] word_index(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[ADDR_W-1:1];
    endfunction
endpackage

// File: rtl/main_mem_responder_pipe.sv
// rtl/main_mem_responder_pipe.sv - LATENCY-deep response shift register with async clear
module mem_resp_pipe
    import main_mem_pkg::*;
#(
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pipe_stage_t stage_in,
    output pipe_stage_t stage_out
);
    pipe_stage_t stages [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= stage_in;
            for (int i = 1; i < LATENCY; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign stage_out = stages[LATENCY-1];
endmodule

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - pipelined single-port main memory answering cache line fills and write-throughs
// Optional misaligned-request checking: MAIN_MEM_ALIGN_CHECK_EN.
module main_mem_responder
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 32768,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] data_in,
    input  logic              enable,
    input  logic              wr,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic              err
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [ADDR_W-2:0] idx;
    logic              in_range;
    logic              misalign;
    logic              rd_req;
    logic              wr_req;
    logic              wr_err_q;
    pipe_stage_t       stage_in;
    pipe_stage_t       stage_out;

`ifdef MAIN_MEM_ALIGN_CHECK_EN
    assign misalign = addr[0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign misalign        = 1'b0;
`endif

    assign idx      = word_index(addr);
    assign in_range = 32'(idx) < DEPTH_WORDS;
    assign rd_req   = enable & ~wr;
    assign wr_req   = enable & wr;

    always_ff @(posedge clk) begin
        if (wr_req && in_range && !misalign) begin
            mem[idx] <= data_in;
        end
    end

    // Sampled before this edge's write can land; a single port never has both anyway.
    always_comb begin
        stage_in       = '0;
        stage_in.valid = rd_req;
        stage_in.err   = rd_req & misalign;
        if (rd_req && in_range && !misalign) begin
            stage_in.data = mem[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_req & misalign;
        end
    end

    mem_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .stage_in (stage_in),
        .stage_out(stage_out)
    );

    assign data_valid = stage_out.valid;
    assign data_out   = stage_out.data;
    assign err        = stage_out.err | wr_err_q;
endmodule
